// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer: advances the PC, applies branch/jump
// redirects, and buffers a redirect that lands during an I-cache miss.
module pc_fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        JumpOP,
    input  logic              ctrl_valid,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [15:0]       imm,
    input  logic [25:0]       jaddr,
    input  logic [ADDR_W-1:0] rs_data,
    input  logic              stall,
    input  logic              fetch_ready,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic              instr_valid,
    output logic              flush,
    output logic [ADDR_W-1:0] link_addr,
    output logic              misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_MISS  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pend_tgt_q;
    logic              pending_q;
    logic              misalign_q;

    logic              redir;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] target;

    assign redir  = ctrl_valid && (JumpOP != 2'b00);
    assign seq_pc = br_pc + WORD;
    assign br_off = {{(ADDR_W-18){imm[15]}}, imm, 2'b00};

    always_comb begin
        target = seq_pc;
        case (JumpOP)
            2'b01:   target = seq_pc + br_off;
            2'b10:   target = {rs_data[ADDR_W-1:2], 2'b00};
            2'b11:   target = {seq_pc[ADDR_W-1:ADDR_W-4], jaddr, 2'b00};
            default: target = seq_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            pend_tgt_q <= '0;
            pending_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            if (redir && (JumpOP == 2'b10) && (rs_data[1:0] != 2'b00))
                misalign_q <= 1'b1;

            case (state_q)
                S_IDLE:  state_q <= S_FETCH;
                S_FETCH: if (!fetch_ready) state_q <= S_MISS;
                S_MISS:  if (fetch_ready) state_q <= S_FETCH;
                default: state_q <= S_IDLE;
            endcase

            // Redirects outrank stall; a redirect arriving mid-miss is parked
            // and the newest one replaces any older parked target.
            if (state_q != S_IDLE) begin
                if (redir && fetch_ready) begin
                    pc_q      <= target;
                    pending_q <= 1'b0;
                end else if (redir) begin
                    pending_q  <= 1'b1;
                    pend_tgt_q <= target;
                end else if (pending_q && fetch_ready) begin
                    pc_q      <= pend_tgt_q;
                    pending_q <= 1'b0;
                end else if (!stall && fetch_ready) begin
                    pc_q <= pc_q + WORD;
                end
            end
        end
    end

    assign fetch_req    = (state_q != S_IDLE);
    assign fetch_addr   = pc_q;
    assign flush        = redir;
    assign link_addr    = seq_pc;
    assign misalign_err = misalign_q;
    assign instr_valid  = fetch_ready && fetch_req && !stall && !redir && !pending_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a per-cycle vector table plus a
// hand-written reset-during-pending-miss sequence.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  JumpOP = '0;
    logic        ctrl_valid = 1'b0;
    logic [31:0] br_pc = '0;
    logic [15:0] imm = '0;
    logic [25:0] jaddr = '0;
    logic [31:0] rs_data = '0;
    logic        stall = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        instr_valid;
    logic        flush;
    logic [31:0] link_addr;
    logic        misalign_err;

    int n_pass = 0;
    int n_total = 0;

    pc_fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .JumpOP(JumpOP), .ctrl_valid(ctrl_valid),
        .br_pc(br_pc), .imm(imm), .jaddr(jaddr), .rs_data(rs_data),
        .stall(stall), .fetch_ready(fetch_ready), .fetch_req(fetch_req),
        .fetch_addr(fetch_addr), .instr_valid(instr_valid), .flush(flush),
        .link_addr(link_addr), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cv;
        logic [1:0]  op;
        logic [31:0] bpc;
        logic [15:0] im;
        logic [25:0] ja;
        logic [31:0] rs;
        logic        st;
        logic        rdy;
        logic        e_flush;
        logic        e_iv;
        logic [31:0] e_link;
        logic [31:0] e_pc;   // fetch_addr after the clock edge
        logic        e_mis;  // misalign_err after the clock edge
    } vec_t;

    localparam int NV = 30;
    vec_t tbl[NV];

    function automatic vec_t mk(logic cv, logic [1:0] op, logic [31:0] bpc,
                                logic [15:0] im, logic [25:0] ja, logic [31:0] rs,
                                logic st, logic rdy, logic e_flush, logic e_iv,
                                logic [31:0] e_link, logic [31:0] e_pc, logic e_mis);
        vec_t v;
        v.cv = cv; v.op = op; v.bpc = bpc; v.im = im; v.ja = ja; v.rs = rs;
        v.st = st; v.rdy = rdy; v.e_flush = e_flush; v.e_iv = e_iv;
        v.e_link = e_link; v.e_pc = e_pc; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input vec_t v);
        ctrl_valid = v.cv; JumpOP = v.op; br_pc = v.bpc; imm = v.im;
        jaddr = v.ja; rs_data = v.rs; stall = v.st; fetch_ready = v.rdy;
    endtask

    task automatic apply(input int idx, input vec_t v);
        logic [31:0] pc_before;
        pc_before = fetch_addr;
        drive(v);
        @(negedge clk);
        chk($sformatf("v%0d fetch_req", idx), 32'(fetch_req), 32'd1);
        chk($sformatf("v%0d flush", idx), 32'(flush), 32'(v.e_flush));
        chk($sformatf("v%0d instr_valid", idx), 32'(instr_valid), 32'(v.e_iv));
        chk($sformatf("v%0d link_addr", idx), link_addr, v.e_link);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d fetch_addr", idx), fetch_addr, v.e_pc);
        chk($sformatf("v%0d misalign_err", idx), 32'(misalign_err), 32'(v.e_mis));
        $display("vec %0d: pc %h -> %h  flush=%b iv=%b link=%h", idx, pc_before,
                 fetch_addr, v.e_flush, v.e_iv, v.e_link);
    endtask

    vec_t idle_v;

    initial begin
        //            cv op     br_pc         imm       jaddr      rs            st rdy fl iv link          next pc       mis
        tbl[0]  = mk(0, 2'b00, 32'h0,        16'h0,    26'h0,     32'h0,        0, 1,  0, 1, 32'h4,        32'h4,        0);
        tbl[1]  = mk(0, 2'b00, 32'h0,        16'h0,    26'h0,     32'h0,        0, 1,  0, 1, 32'h4,        32'h8,        0);
        tbl[2]  = mk(0, 2'b00, 32'h0,        16'h0,    26'h0,     32'h0,        0, 1,  0, 1, 32'h4,        32'hC,        0);
        tbl[3]  = mk(0, 2'b00, 32'h0,        16'h0,    26'h0,     32'h0,        0, 1,  0, 1, 32'h4,        32'h10,       0);
        tbl[4]  = mk(1, 2'b01, 32'hC,        16'hFFFE, 26'h0,     32'h0,        0, 1,  1, 0, 32'h10,       32'h8,        0);
        tbl[5]  = mk(0, 2'b00, 32'h0,        16'h0,    26'h0,     32'h0,        0, 1,  0, 1, 32'h4,        32'hC,        0);
        tbl[6]  = mk(1, 2'b11, 32'h1000_0040, 16'h0,   26'h100,   32'h0,        0, 1,  1, 0, 32'h1000_0044, 32'h1000_0400, 0);
        tbl[7]  = mk(1, 2'b10, 32'h0,        16'h0,    26'h0,     32'h2003,     0, 1,  1, 0, 32'h4,        32'h2000,     1);
        tbl[8]  = mk(0, 2'b00, 32'h0,        16'h0,    26'h0,     32'h0,        0, 1,  0, 1, 32'h4,        32'h2004,     1);
        tbl[9]  = mk(1, 2'b11, 32'h0,        16'h0,    26'h8,     32'h0,        0, 1,  1, 0, 32'h4,        32'h20,       1);
        // miss at 0x20, redirect to 0x400 parked in miss cycle 2
        tbl[10] = mk(0, 2'b00, 32'h0,        16'h0,    26'h0,     32'h0,        0, 0,  0, 0, 32'h4,        32'h20,       1);
        tbl[11] = mk(1, 2'b11, 32'h0,        16'h0,    26'h100,   32'h0,        0, 0,  1, 0, 32'h4,        32'h20,       1);
        tbl[12] = mk(0, 2'b00, 32'h0,        16'h0,    26'h0,     32'h0,        0, 0,  0, 0, 32'h4,        32'h20,       1);
        tbl[13] = mk(0, 2'b00, 32'h0,        16'h0,    26'h0,     32'h0,        0, 1,  0, 0, 32'h4,        32'h400,      1);
        tbl[14] = mk(1, 2'b11, 32'h0,        16'h0,    26'hC,     32'h0,        0, 1,  1, 0, 32'h4,        32'h30,       1);
        // stall at 0x30, then a branch while stalled
        tbl[15] = mk(0, 2'b00, 32'h0,        16'h0,    26'h0,     32'h0,        1, 1,  0, 0, 32'h4,        32'h30,       1);
        tbl[16] = mk(0, 2'b00, 32'h0,        16'h0,    26'h0,     32'h0,        1, 1,  0, 0, 32'h4,        32'h30,       1);
        tbl[17] = mk(0, 2'b00, 32'h0,        16'h0,    26'h0,     32'h0,        0, 1,  0, 1, 32'h4,        32'h34,       1);
        tbl[18] = mk(1, 2'b01, 32'h34,       16'h0003, 26'h0,     32'h0,        1, 1,  1, 0, 32'h38,       32'h44,       1);
        tbl[19] = mk(0, 2'b00, 32'h0,        16'h0,    26'h0,     32'h0,        0, 1,  0, 1, 32'h4,        32'h48,       1);
        // top-of-address-space wrap
        tbl[20] = mk(1, 2'b10, 32'h0,        16'h0,    26'h0,     32'hFFFF_FFFC, 0, 1, 1, 0, 32'h4,        32'hFFFF_FFFC, 1);
        tbl[21] = mk(0, 2'b00, 32'h0,        16'h0,    26'h0,     32'h0,        0, 1,  0, 1, 32'h4,        32'h0,        1);
        // two redirects during one miss: the newer target wins
        tbl[22] = mk(0, 2'b00, 32'h0,        16'h0,    26'h0,     32'h0,        0, 0,  0, 0, 32'h4,        32'h0,        1);
        tbl[23] = mk(1, 2'b11, 32'h0,        16'h0,    26'h40,    32'h0,        0, 0,  1, 0, 32'h4,        32'h0,        1);
        tbl[24] = mk(1, 2'b11, 32'h0,        16'h0,    26'h80,    32'h0,        0, 0,  1, 0, 32'h4,        32'h0,        1);
        tbl[25] = mk(0, 2'b00, 32'h0,        16'h0,    26'h0,     32'h0,        0, 1,  0, 0, 32'h4,        32'h200,      1);
        tbl[26] = mk(0, 2'b00, 32'h0,        16'h0,    26'h0,     32'h0,        0, 1,  0, 1, 32'h4,        32'h204,      1);
        // redirect arriving on the miss-completing cycle applies directly
        tbl[27] = mk(0, 2'b00, 32'h0,        16'h0,    26'h0,     32'h0,        0, 0,  0, 0, 32'h4,        32'h204,      1);
        tbl[28] = mk(1, 2'b10, 32'h0,        16'h0,    26'h0,     32'h300,      0, 1,  1, 0, 32'h4,        32'h300,      1);
        tbl[29] = mk(0, 2'b00, 32'h0,        16'h0,    26'h0,     32'h0,        0, 1,  0, 1, 32'h4,        32'h304,      1);

        idle_v = mk(0, 2'b00, 32'h0, 16'h0, 26'h0, 32'h0, 0, 1, 0, 0, 32'h4, 32'h0, 0);

        // reset state
        drive(idle_v);
        repeat (2) @(posedge clk);
        #1;
        chk("rst fetch_req", 32'(fetch_req), 32'd0);
        chk("rst fetch_addr", fetch_addr, 32'h0);
        chk("rst instr_valid", 32'(instr_valid), 32'd0);
        chk("rst flush", 32'(flush), 32'd0);
        chk("rst misalign_err", 32'(misalign_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle fetch_req", 32'(fetch_req), 32'd0);
        chk("idle instr_valid", 32'(instr_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("first fetch_addr", fetch_addr, 32'h0);
        $display("reset released: fetch_addr=%h fetch_req=%b", fetch_addr, fetch_req);

        for (int i = 0; i < NV; i++) apply(i, tbl[i]);

        // reset asserted mid-miss with a parked redirect
        drive(mk(0, 2'b00, 32'h0, 16'h0, 26'h0, 32'h0, 0, 0, 0, 0, 32'h4, 32'h0, 0));
        @(posedge clk);
        #1;
        drive(mk(1, 2'b11, 32'h0, 16'h0, 26'h100, 32'h0, 0, 0, 0, 0, 32'h4, 32'h0, 0));
        @(posedge clk);
        #1;
        chk("pend held pc", fetch_addr, 32'h304);
        drive(mk(0, 2'b00, 32'h0, 16'h0, 26'h0, 32'h0, 0, 0, 0, 0, 32'h4, 32'h0, 0));
        #2;
        rst = 1'b0;
        #1;
        chk("midrst fetch_req", 32'(fetch_req), 32'd0);
        chk("midrst fetch_addr", fetch_addr, 32'h0);
        chk("midrst misalign_err", 32'(misalign_err), 32'd0);
        chk("midrst instr_valid", 32'(instr_valid), 32'd0);
        $display("mid-miss reset: fetch_addr=%h fetch_req=%b", fetch_addr, fetch_req);
        @(negedge clk);
        rst = 1'b1;
        fetch_ready = 1'b1;
        #1;
        chk("rerel fetch_req", 32'(fetch_req), 32'd0);
        @(posedge clk);
        #1;
        chk("rerel fetch_addr", fetch_addr, 32'h0);
        @(negedge clk);
        chk("rerel instr_valid", 32'(instr_valid), 32'd1);
        @(posedge clk);
        #1;
        chk("rerel next pc", fetch_addr, 32'h4);
        $display("restart: fetch_addr=%h", fetch_addr);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter and fetch-sequencing stage that consumes the 2-bit JumpOP redirect code from the jump/branch control block. It holds the PC, computes the next PC (sequential, branch, register jump, absolute jump), and drives fetch requests to the instruction cache. It stalls on cache misses and hazards. A redirect that arrives during a miss is buffered and applied when the miss completes.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC/address width (fixed at 32 for MIPS; kept for bench sizing)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
JumpOP  input  2  redirect code: 00 none, 01 taken branch, 10 jr/jalr, 11 j/jal
ctrl_valid  input  1  JumpOP/br_pc/imm/jaddr/rs_data are valid this cycle
br_pc  input  32  PC of the instruction carrying JumpOP
imm  input  16  branch offset (words), sign-extended internally
jaddr  input  26  j/jal target field
rs_data  input  32  register target for jr/jalr
stall  input  1  hazard stall; hold PC
fetch_ready  input  1  I-cache returns the instruction for fetch_addr this cycle
fetch_req  output  1  fetch request to I-cache
fetch_addr  output  32  current PC
instr_valid  output  1  fetched instruction accepted into IF/ID this cycle
flush  output  1  squash younger in-flight instructions
link_addr  output  32  br_pc+4, return address for jal/jalr
misalign_err  output  1  sticky: a jr/jalr target had rs_data[1:0]!=0

Behaviour:
- Reset (rst=0, asynchronous): PC=RESET_PC, state=IDLE, pending cleared. fetch_req=0, instr_valid=0, flush=0, misalign_err=0. link_addr is combinational.
- States: IDLE -> FETCH unconditionally on the first clock after reset release. FETCH -> MISS when fetch_req=1 and fetch_ready=0. MISS -> FETCH when fetch_ready=1.
- fetch_req=1 in FETCH and MISS. fetch_addr=PC at all times.
- Redirect: redir = ctrl_valid && JumpOP!=00. Target:
  - 01: br_pc+4+(sext(imm)<<2), 32-bit wrap.
  - 10: {rs_data[31:2],2'b00}. Set misalign_err if rs_data[1:0]!=0.
  - 11: {(br_pc+4)[31:28], jaddr, 2'b00}.
- flush=1 combinationally in exactly the cycle redir=1; otherwise 0.
- instr_valid = fetch_ready && fetch_req && !stall && !redir && !pending.
- PC update priority, highest first:
  - (1) redir && fetch_ready in FETCH/MISS: PC<=target. The instruction returned this cycle is dropped. This applies even when stall=1: a redirect overrides stall.
  - (2) redir && !fetch_ready: pending<=1, pend_tgt<=target, PC held.
  - (3) pending && fetch_ready: PC<=pend_tgt, pending<=0, returned instruction dropped.
  - (4) stall: PC held.
  - (5) fetch_ready: PC<=PC+4, 32-bit wrap, FFFF_FFFC -> 0000_0000.
  - (6) else hold.
- A second redir while pending overwrites pend_tgt. The newest redirect wins.
- Reset mid-miss or with pending set: all state is cleared immediately and fetch restarts from RESET_PC. No stale target survives.
- Latency: a redirect target appears on fetch_addr the cycle after redir when fetch_ready=1. Otherwise it appears the cycle after the miss completes.

Test Plan:
- Reset release, fetch_ready=1 constant -> fetch_addr sequence 0x0, 0x4, 0x8. fetch_req=0 in first cycle after release. instr_valid=1 from cycle 2.
- At PC=0x10: ctrl_valid=1, JumpOP=01, br_pc=0x0C, imm=16'hFFFE -> flush=1 for one cycle. Next fetch_addr=0x08. link_addr=0x10.
- JumpOP=11, br_pc=0x1000_0040, jaddr=26'h000_0100 -> next fetch_addr=0x1000_0400. JumpOP=10, rs_data=0x0000_2003 -> fetch_addr=0x0000_2000 and misalign_err stays 1 until reset.
- fetch_ready=0 for 3 cycles at PC=0x20. Redirect JumpOP=11 (target 0x400) in miss cycle 2. Then fetch_ready=1 -> PC held at 0x20 through the miss. The returned instruction is dropped (instr_valid=0). Next fetch_addr=0x400.
- stall=1 for 2 cycles with fetch_ready=1 at PC=0x30 -> fetch_addr stays 0x30 and instr_valid=0. After release PC advances to 0x34. A redirect while stall=1 still updates PC.
- Assert rst low mid-miss with pending set -> outputs reset immediately. After release, fetch restarts at RESET_PC with pending=0.
